// File: rtl/btn_loader_pkg.sv
// Shared types and helpers for the button word loader.
package btn_loader_pkg;

  typedef enum logic {StCollect, StHold} state_e;

  localparam int unsigned DefDataW = 48;

  function automatic int unsigned cnt_w(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/btn_loader_shreg.sv
// Bit accumulator: shift-in (MSB-first) or indexed write (LSB-first), with bit count and full flag.
module btn_loader_shreg
  import btn_loader_pkg::*;
#(
  parameter int unsigned DATA_W    = DefDataW,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       accept,
  input  logic                       bit_val,
  output logic [DATA_W-1:0]          data_d,
  output logic [cnt_w(DATA_W)-1:0]   count,
  output logic                       full
);

  localparam int unsigned CntW = cnt_w(DATA_W);

  logic [DATA_W-1:0] data_q;
  logic [CntW-1:0]   count_d;

  always_comb begin
    data_d  = data_q;
    count_d = count;
    if (clr) begin
      data_d  = '0;
      count_d = '0;
    end else if (accept) begin
      if (MSB_FIRST) begin
        data_d = {data_q[DATA_W-2:0], bit_val};
      end else begin
        for (int unsigned i = 0; i < DATA_W; i++) begin
          if (CntW'(i) == count) data_d[i] = bit_val;
        end
      end
      count_d = count + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
    count  <= count_d;
    full   <= (count_d == CntW'(DATA_W));
  end

endmodule

// File: rtl/btn_word_loader.sv
// Serial word loader: assembles a word from bit-0/bit-1 pulses and offers it on valid/ready.
// Optional BTN_LOADER_PARITY_EN adds o_parity, the XOR of the committed word.
module btn_word_loader
  import btn_loader_pkg::*;
#(
  parameter int unsigned DATA_W      = DefDataW,
  parameter bit          MSB_FIRST   = 1'b1,
  parameter bit          AUTO_COMMIT = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_bit0,
  input  logic                     i_bit1,
  input  logic                     i_commit,
  input  logic                     i_clear,
  output logic [DATA_W-1:0]        o_word,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [cnt_w(DATA_W)-1:0] o_count,
  output logic                     o_full,
  output logic                     o_overflow,
`ifdef BTN_LOADER_PARITY_EN
  output logic                     o_parity,
`endif
  output logic                     o_collision
);

  localparam int unsigned CntW = cnt_w(DATA_W);

  state_e            state_q;
  logic              bit_one, bit_both, accept, commit, handshake, shreg_clr;
  logic [DATA_W-1:0] shreg_d;

  always_comb begin
    bit_both  = i_bit0 & i_bit1;
    bit_one   = i_bit0 ^ i_bit1;
    accept    = (state_q == StCollect) && bit_one && !o_full && !i_clear;
    handshake = (state_q == StHold) && i_ready;
    // A bit accepted in the same cycle counts toward a non-empty word.
    commit    = (state_q == StCollect) && !i_clear &&
                ((i_commit && ((o_count != '0) || accept)) ||
                 (AUTO_COMMIT && accept && (o_count == CntW'(DATA_W - 1))));
    shreg_clr = rst | i_clear | handshake;
  end

  btn_loader_shreg #(
    .DATA_W    (DATA_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk     (clk),
    .clr     (shreg_clr),
    .accept  (accept),
    .bit_val (i_bit1),
    .data_d  (shreg_d),
    .count   (o_count),
    .full    (o_full)
  );

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      state_q     <= StCollect;
      o_word      <= '0;
      o_valid     <= 1'b0;
      o_overflow  <= 1'b0;
      o_collision <= 1'b0;
`ifdef BTN_LOADER_PARITY_EN
      o_parity    <= 1'b0;
`endif
    end else begin
      if (bit_both) begin
        o_collision <= 1'b1;
      end else if (bit_one && ((state_q == StHold) || o_full)) begin
        o_overflow <= 1'b1;
      end
      if (commit) begin
        state_q <= StHold;
        o_valid <= 1'b1;
        o_word  <= shreg_d;
`ifdef BTN_LOADER_PARITY_EN
        o_parity <= ^shreg_d;
`endif
      end else if (handshake) begin
        state_q <= StCollect;
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_btn_word_loader.sv
// Randomized scoreboard bench for btn_word_loader: one MSB-first auto-commit instance and one
// LSB-first manual-commit instance share stimulus and are checked against a bit-list model.
module tb_btn_word_loader;

  logic clk = 1'b0;
  logic rst = 1'b1, bit0 = 1'b0, bit1 = 1'b0, commit = 1'b0, clear = 1'b0, ready = 1'b0;
  logic [47:0] wa, wb;
  logic        va, vb, fa, fb, oa, ob, xa, xb;
  logic [5:0]  ca, cb;
`ifdef BTN_LOADER_PARITY_EN
  logic        pa, pb;
`endif

  always #5 clk = ~clk;

  btn_word_loader dut_a (
    .clk(clk), .rst(rst), .i_bit0(bit0), .i_bit1(bit1), .i_commit(commit), .i_clear(clear),
    .o_word(wa), .o_valid(va), .i_ready(ready), .o_count(ca), .o_full(fa), .o_overflow(oa),
`ifdef BTN_LOADER_PARITY_EN
    .o_parity(pa),
`endif
    .o_collision(xa)
  );

  btn_word_loader #(.DATA_W(48), .MSB_FIRST(1'b0), .AUTO_COMMIT(1'b0)) dut_b (
    .clk(clk), .rst(rst), .i_bit0(bit0), .i_bit1(bit1), .i_commit(commit), .i_clear(clear),
    .o_word(wb), .o_valid(vb), .i_ready(ready), .o_count(cb), .o_full(fb), .o_overflow(ob),
`ifdef BTN_LOADER_PARITY_EN
    .o_parity(pb),
`endif
    .o_collision(xb)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: bits kept in arrival order; word built from that list on commit.
  logic [47:0] m_seq [2];
  int          m_n   [2];
  bit          m_hold[2], m_ovf[2], m_col[2], m_zero[2];
  logic [47:0] m_word[2];
  logic [47:0] exp_q0[$];
  logic [47:0] exp_q1[$];

  function automatic logic [47:0] assemble(input int m);
    logic [47:0] v = '0;
    for (int i = 0; i < m_n[m]; i++) begin
      if (m == 0) v = {v[46:0], m_seq[m][i]};  // first bit ends up most significant
      else        v[i] = m_seq[m][i];
    end
    return v;
  endfunction

  task automatic model_step(input int m, input bit b0, b1, cm, cl, rdy, rs);
    bit acc = 1'b0;
    bit auto_c = (m == 0);
    if (rs || cl) begin
      m_n[m] = 0; m_seq[m] = '0; m_hold[m] = 0; m_ovf[m] = 0; m_col[m] = 0;
      m_word[m] = '0; m_zero[m] = 1;
      if (m == 0) exp_q0.delete(); else exp_q1.delete();
      return;
    end
    if (!m_hold[m]) begin
      if (b0 && b1) m_col[m] = 1;
      else if (b0 || b1) begin
        if (m_n[m] == 48) m_ovf[m] = 1;
        else begin
          m_seq[m][m_n[m]] = b1;
          m_n[m]++;
          acc = 1;
        end
      end
      if ((cm && m_n[m] > 0) || (auto_c && acc && m_n[m] == 48)) begin
        m_word[m] = assemble(m);
        m_hold[m] = 1;
        m_zero[m] = 0;
        if (m == 0) exp_q0.push_back(m_word[m]); else exp_q1.push_back(m_word[m]);
      end
    end else begin
      if (b0 && b1) m_col[m] = 1;
      else if (b0 || b1) m_ovf[m] = 1;
      if (rdy) begin
        m_hold[m] = 0;
        m_n[m] = 0;
        m_seq[m] = '0;
      end
    end
  endtask

  task automatic check_outputs(input int m);
    string pre = (m == 0) ? "a_" : "b_";
    logic [47:0] w = (m == 0) ? wa : wb;
    logic [5:0]  c = (m == 0) ? ca : cb;
    logic v = (m == 0) ? va : vb;
    logic f = (m == 0) ? fa : fb;
    logic o = (m == 0) ? oa : ob;
    logic x = (m == 0) ? xa : xb;
    chk({pre, "count"}, 64'(c), 64'(m_n[m]));
    chk({pre, "full"}, 64'(f), 64'(m_n[m] == 48));
    chk({pre, "valid"}, 64'(v), 64'(m_hold[m]));
    chk({pre, "overflow"}, 64'(o), 64'(m_ovf[m]));
    chk({pre, "collision"}, 64'(x), 64'(m_col[m]));
    if (m_hold[m] || m_zero[m]) begin
      chk({pre, "word"}, 64'(w), 64'(m_word[m]));
`ifdef BTN_LOADER_PARITY_EN
      chk({pre, "parity"}, 64'((m == 0) ? pa : pb), 64'(^m_word[m]));
`endif
    end
  endtask

  task automatic cycle(input bit b0, b1, cm, cl, rdy, rs);
    bit0 = b0; bit1 = b1; commit = cm; clear = cl; ready = rdy; rst = rs;
    model_step(0, b0, b1, cm, cl, rdy, rs);
    model_step(1, b0, b1, cm, cl, rdy, rs);
    @(posedge clk);
    #1;
    check_outputs(0);
    check_outputs(1);
  endtask

  // Monitor: each accepted word is popped from its queue and compared.
  always @(negedge clk) begin
    logic [47:0] w;
    if (!rst && !clear && ready) begin
      if (va) begin
        if (exp_q0.size() == 0) chk("a_unexpected_valid", 64'(va), 64'(0));
        else begin
          w = exp_q0.pop_front();
          chk("a_word_handshake", 64'(wa), 64'(w));
`ifdef BTN_LOADER_PARITY_EN
          chk("a_parity_handshake", 64'(pa), 64'(^w));
`endif
        end
      end
      if (vb) begin
        if (exp_q1.size() == 0) chk("b_unexpected_valid", 64'(vb), 64'(0));
        else begin
          w = exp_q1.pop_front();
          chk("b_word_handshake", 64'(wb), 64'(w));
`ifdef BTN_LOADER_PARITY_EN
          chk("b_parity_handshake", 64'(pb), 64'(^w));
`endif
        end
      end
    end
  end

  initial begin
    #1;
    repeat (3) cycle(0, 0, 0, 0, 0, 1);

    // 40 ones then 8 zeros, consumer not ready
    repeat (40) cycle(0, 1, 0, 0, 0, 0);
    repeat (8)  cycle(1, 0, 0, 0, 0, 0);
    chk("plan_a_word", 64'(wa), 64'h0000_FFFF_FFFF_FF00);
    chk("plan_a_valid", 64'(va), 64'(1));
    repeat (2) cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0);
    chk("plan_b_word", 64'(wb), 64'h0000_00FF_FFFF_FFFF);
    cycle(0, 1, 0, 0, 0, 0);
    chk("plan_b_overflow", 64'(ob), 64'(1));
    chk("plan_b_word_kept", 64'(wb), 64'h0000_00FF_FFFF_FFFF);
    cycle(0, 0, 0, 0, 1, 0);
    chk("plan_a_count_after_hs", 64'(ca), 64'(0));
    cycle(0, 0, 0, 1, 0, 0);

    // 1,0,1 then commit; then 1,1,1 with commit on the last bit
    cycle(0, 1, 0, 0, 0, 0); cycle(1, 0, 0, 0, 0, 0); cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0);
    chk("plan_a_word5", 64'(wa), 64'h5);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 1, 0, 0, 0, 0); cycle(0, 1, 0, 0, 0, 0); cycle(0, 1, 1, 0, 0, 0);
    chk("plan_a_word7", 64'(wa), 64'h7);
    cycle(0, 0, 0, 0, 1, 0);

    // collision leaves count alone; commit on empty word is ignored
    cycle(0, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    chk("plan_collision", 64'(xa), 64'(1));
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0, 0);
    chk("plan_empty_commit", 64'(va), 64'(0));

    // clear while holding, reset mid-word
    cycle(0, 1, 1, 0, 0, 0);
    cycle(1, 1, 0, 1, 1, 0);
    chk("plan_clear_valid", 64'(va), 64'(0));
    chk("plan_clear_word", 64'(wa), 64'(0));
    cycle(0, 1, 0, 0, 0, 0); cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 1);
    chk("plan_reset_count", 64'(ca), 64'(0));

    for (int ph = 0; ph < 4; ph++) begin
      int unsigned cprob = (ph == 0) ? 8 : (ph == 1) ? 100 : (ph == 2) ? 30 : 400;
      for (int k = 0; k < 1500; k++) begin
        int unsigned r = $urandom_range(0, 15);
        bit b0 = (r < 5) || (r == 10);
        bit b1 = (r >= 5 && r < 11);
        cycle(b0, b1, $urandom_range(0, cprob) == 0, $urandom_range(0, 199) == 0,
              $urandom_range(0, 2) == 0, $urandom_range(0, 499) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
